// File: rtl/fifo_test_sequencer.sv
// Stimulus/check controller for a FIFO under test: runs fill, full-check, drain and
// empty-check rounds, compares read data against an incrementing pattern and pulses pass/fail.
module fifo_test_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_ROUNDS = 2,
  parameter int unsigned SEED       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              full,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic              pass_pulse,
  output logic              fail_pulse,
  output logic              busy,
  output logic              done,
  output logic [15:0]       fail_cnt
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned RW  = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned FCW = 16;

  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [RW-1:0]     NROUNDS_C = RW'(NUM_ROUNDS);
  localparam logic [DATA_W-1:0] SEED_C    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STEP_C    = DATA_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FULL_CHK,
    S_DRAIN,
    S_EMPTY_CHK,
    S_DONE
  } state_e;

  state_e            state_q,    state_d;
  logic [DATA_W-1:0] base_q,     base_d;
  logic [RW-1:0]     round_q,    round_d;
  logic [CW-1:0]     wr_cnt_q,   wr_cnt_d;
  logic [CW-1:0]     exp_cnt_q,  exp_cnt_d;
  logic [CW-1:0]     rd_cnt_q,   rd_cnt_d;
  logic [CW-1:0]     cmp_cnt_q,  cmp_cnt_d;
  logic              rd_vld_q,   rd_vld_d;
  logic              pass_q,     pass_d;
  logic              fail_q,     fail_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [FCW-1:0]    fail_cnt_q, fail_cnt_d;

  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [DATA_W-1:0] exp_data_c;

  // Next-state, strobes and check results
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    round_d    = round_q;
    wr_cnt_d   = wr_cnt_q;
    exp_cnt_d  = exp_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    cmp_cnt_d  = cmp_cnt_q;
    fail_cnt_d = fail_cnt_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;

    wr_en_c    = (state_q == S_FILL) && !full && (wr_cnt_q < DEPTH_C);
    wr_data_c  = (state_q == S_FILL) ? (base_q + DATA_W'(wr_cnt_q)) : '0;
    rd_en_c    = (state_q == S_DRAIN) && !empty && (rd_cnt_q < exp_cnt_q);
    rd_vld_d   = rd_en_c;
    exp_data_c = base_q + DATA_W'(cmp_cnt_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d     = SEED_C;
          round_d    = '0;
          fail_cnt_d = '0;
          wr_cnt_d   = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (wr_en_c) wr_cnt_d = wr_cnt_q + CW'(1);
        // A full flag before DEPTH words is a premature-full, judged in FULL_CHK
        if ((wr_cnt_q == DEPTH_C) || full) begin
          exp_cnt_d = wr_cnt_q;
          state_d   = S_FULL_CHK;
        end
      end
      S_FULL_CHK: begin
        if (full && (exp_cnt_q == DEPTH_C)) pass_d = 1'b1;
        else                                fail_d = 1'b1;
        rd_cnt_d  = '0;
        cmp_cnt_d = '0;
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_en_c) rd_cnt_d = rd_cnt_q + CW'(1);
        if (rd_vld_q) begin
          if (rd_data == exp_data_c) pass_d = 1'b1;
          else                       fail_d = 1'b1;
          cmp_cnt_d = cmp_cnt_q + CW'(1);
        end
        if (!rd_vld_q && !rd_en_c && ((rd_cnt_q == exp_cnt_q) || empty)) begin
          state_d = S_EMPTY_CHK;
        end
      end
      S_EMPTY_CHK: begin
        if (empty && (cmp_cnt_q == exp_cnt_q)) pass_d = 1'b1;
        else                                   fail_d = 1'b1;
        round_d = round_q + RW'(1);
        if (round_d == NROUNDS_C) begin
          state_d = S_DONE;
        end else begin
          base_d   = base_q + STEP_C;
          wr_cnt_d = '0;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_d && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + FCW'(1);

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      round_q    <= '0;
      wr_cnt_q   <= '0;
      exp_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      cmp_cnt_q  <= '0;
      rd_vld_q   <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      round_q    <= round_d;
      wr_cnt_q   <= wr_cnt_d;
      exp_cnt_q  <= exp_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      cmp_cnt_q  <= cmp_cnt_d;
      rd_vld_q   <= rd_vld_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign wr_en      = wr_en_c;
  assign wr_data    = wr_data_c;
  assign rd_en      = rd_en_c;
  assign pass_pulse = pass_q;
  assign fail_pulse = fail_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail_cnt   = fail_cnt_q;

endmodule
